// File: rtl/trajectory_mem_reader_pkg.sv
// Shared constants and FSM encodings for the trajectory RAM reader and writer-side code.
package trajectory_mem_reader_pkg;

  localparam int unsigned TRAJ_DEPTH    = 400;
  localparam int unsigned TRAJ_ADDR_W   = 9;
  localparam int unsigned TRAJ_DATA_W   = 19;
  localparam int unsigned SCREEN_PIXELS = 307200;

  typedef logic [2:0] state_t;

  localparam state_t StIdle    = 3'd0;
  localparam state_t StLoad    = 3'd1;
  localparam state_t StIssue   = 3'd2;
  localparam state_t StWait    = 3'd3;
  localparam state_t StPresent = 3'd4;
  localparam state_t StFin     = 3'd5;

endpackage

// File: rtl/trajectory_mem_reader.sv
// Walks the trajectory RAM once per start pulse and streams stored pixel addresses to the painter.
// Optional off-screen filtering and drop counter when TRAJ_BOUNDS_CHECK_EN is defined.
module trajectory_mem_reader
  import trajectory_mem_reader_pkg::*;
#(
  parameter int unsigned DEPTH      = TRAJ_DEPTH,
  parameter int unsigned ADDR_W     = TRAJ_ADDR_W,
  parameter int unsigned DATA_W     = TRAJ_DATA_W,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_entries,
  output logic [ADDR_W-1:0] rd_draw_add,
  input  logic [DATA_W-1:0] rd_draw_out,
  output logic [DATA_W-1:0] pix_addr,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              busy,
  output logic              done
`ifdef TRAJ_BOUNDS_CHECK_EN
  ,
  output logic [ADDR_W-1:0] drop_count
`endif
);

  localparam int unsigned     CNT_W     = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RD_LATENCY - 1);
  localparam logic [ADDR_W:0]  DEPTH_W   = (ADDR_W + 1)'(DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] limit_q, limit_d;
  logic [CNT_W-1:0]  wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] rd_add_q, rd_add_d;
  logic [DATA_W-1:0] pix_addr_q, pix_addr_d;
  logic              pix_valid_q, pix_valid_d;
  logic [ADDR_W:0]   idx_inc;
  logic              last_entry;
  logic              capture;
  logic              offscreen;

  assign idx_inc    = {1'b0, idx_q} + 1'b1;
  assign last_entry = (idx_inc == {1'b0, limit_q});
  assign capture    = (state_q == StWait) && (wcnt_q == WAIT_LAST);

`ifdef TRAJ_BOUNDS_CHECK_EN
  assign offscreen = (rd_draw_out >= DATA_W'(SCREEN_PIXELS));
`else
  assign offscreen = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    limit_d     = limit_q;
    wcnt_d      = wcnt_q;
    rd_add_d    = rd_add_q;
    pix_addr_d  = pix_addr_q;
    pix_valid_d = pix_valid_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          limit_d = ({1'b0, num_entries} > DEPTH_W) ? DEPTH_W[ADDR_W-1:0] : num_entries;
          idx_d   = '0;
          state_d = StLoad;
        end
      end
      StLoad: state_d = (limit_q == '0) ? StFin : StIssue;
      StIssue: begin
        rd_add_d = idx_q;
        wcnt_d   = '0;
        state_d  = StWait;
      end
      StWait: begin
        if (capture) begin
          if (offscreen) begin
            // Dropped entries advance exactly like an accepted handshake.
            idx_d   = idx_inc[ADDR_W-1:0];
            state_d = last_entry ? StFin : StIssue;
          end else begin
            pix_addr_d  = rd_draw_out;
            pix_valid_d = 1'b1;
            state_d     = StPresent;
          end
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      StPresent: begin
        if (pix_ready) begin
          pix_valid_d = 1'b0;
          idx_d       = idx_inc[ADDR_W-1:0];
          state_d     = last_entry ? StFin : StIssue;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      limit_q     <= '0;
      wcnt_q      <= '0;
      rd_add_q    <= '0;
      pix_addr_q  <= '0;
      pix_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      limit_q     <= limit_d;
      wcnt_q      <= wcnt_d;
      rd_add_q    <= rd_add_d;
      pix_addr_q  <= pix_addr_d;
      pix_valid_q <= pix_valid_d;
    end
  end

`ifdef TRAJ_BOUNDS_CHECK_EN
  logic [ADDR_W-1:0] drop_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      drop_q <= '0;
    end else if (state_q == StIdle && start) begin
      drop_q <= '0;
    end else if (capture && offscreen && drop_q != DEPTH_W[ADDR_W-1:0]) begin
      drop_q <= drop_q + 1'b1;
    end
  end

  assign drop_count = drop_q;
`endif

  assign rd_draw_add = rd_add_q;
  assign pix_addr    = pix_addr_q;
  assign pix_valid   = pix_valid_q;
  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StFin);

endmodule

// File: tb/tb_trajectory_mem_reader.sv
// Scoreboard bench for trajectory_mem_reader; covers the TRAJ_BOUNDS_CHECK_EN build when defined.
module tb_trajectory_mem_reader;

  localparam int unsigned DEPTH      = 400;
  localparam int unsigned ADDR_W     = 9;
  localparam int unsigned DATA_W     = 19;
  localparam int unsigned RD_LATENCY = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] num_entries;
  logic [ADDR_W-1:0] rd_draw_add;
  logic [DATA_W-1:0] rd_draw_out;
  logic [DATA_W-1:0] pix_addr;
  logic              pix_valid;
  logic              pix_ready = 1'b0;
  logic              busy;
  logic              done;
`ifdef TRAJ_BOUNDS_CHECK_EN
  logic [ADDR_W-1:0] drop_count;
`endif

  logic [DATA_W-1:0] mem [0:511];
  logic [DATA_W-1:0] sb_q [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_hs_cyc = 0;
  int pass_hs = 0;
  int hs_count = 0;
  int done_count = 0;
  int busy_cycles = 0;
  int max_addr = 0;
  bit ready_rand = 1'b0;
  bit ready_level = 1'b0;
  bit tp_check = 1'b0;
  bit done_after_hs = 1'b0;
  bit stalled = 1'b0;
  logic [DATA_W-1:0] stall_addr = '0;

  trajectory_mem_reader #(
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .RD_LATENCY(RD_LATENCY)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .num_entries(num_entries),
    .rd_draw_add(rd_draw_add),
    .rd_draw_out(rd_draw_out),
    .pix_addr   (pix_addr),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .busy       (busy),
    .done       (done)
`ifdef TRAJ_BOUNDS_CHECK_EN
    ,
    .drop_count (drop_count)
`endif
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // One RAM register after the registered address gives data sampleable RD_LATENCY edges later.
  always @(posedge clock) rd_draw_out <= mem[rd_draw_add];

  always @(posedge clock) begin
    #1;
    pix_ready = ready_rand ? ($urandom_range(0, 9) < 3) : ready_level;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake and checks stream rules.
  always @(negedge clock) begin
    if (reset) begin
      stalled = 1'b0;
    end else begin
      if (int'(rd_draw_add) > max_addr) max_addr = int'(rd_draw_add);
      if (busy) busy_cycles++;
      if (stalled) begin
        chk("stall_valid", 32'(pix_valid), 32'd1);
        chk("stall_addr", 32'(pix_addr), 32'(stall_addr));
      end
      if (pix_valid) begin
        if (pix_ready) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pix: got %0d required no output", pix_addr);
          end else begin
            chk("pix_addr", 32'(pix_addr), 32'(sb_q.pop_front()));
          end
          if (tp_check && pass_hs > 0) chk("throughput", cyc - last_hs_cyc, RD_LATENCY + 2);
          last_hs_cyc = cyc;
          pass_hs++;
          hs_count++;
          stalled = 1'b0;
        end else begin
          stalled    = 1'b1;
          stall_addr = pix_addr;
        end
      end else begin
        stalled = 1'b0;
      end
      if (done) begin
        done_count++;
        if (done_after_hs) chk("done_latency", cyc - last_hs_cyc, 32'd1);
      end
    end
  end

  task automatic do_start(input int n);
    @(posedge clock);
    #1;
    pass_hs     = 0;
    num_entries = ADDR_W'(n);
    start       = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit found = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clock);
      if (done) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done in %0d cycles required done", name, budget);
    end
    @(negedge clock);
    chk({name, "_busy_after"}, 32'(busy), 32'd0);
    chk({name, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) @(negedge clock);
  endtask

  initial begin
    int dc0;
    int hs0;
    bit got;
    reset       = 1'b1;
    start       = 1'b0;
    num_entries = '0;
    for (int i = 0; i < 512; i++) mem[i] = DATA_W'(i * 3);
    idle(3);
    chk("rst_pix_valid", 32'(pix_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rd_add", 32'(rd_draw_add), 32'd0);
    chk("rst_pix_addr", 32'(pix_addr), 32'd0);
    #2 reset = 1'b0;

    // Five entries, ready high; a second start mid-pass must be dropped.
    ready_level   = 1'b1;
    tp_check      = 1'b1;
    done_after_hs = 1'b1;
    for (int i = 0; i < 5; i++) sb_q.push_back(DATA_W'(i * 3));
    dc0 = done_count;
    do_start(5);
    idle(6);
    #1;
    num_entries = 9'd3;
    start       = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    wait_done("pass5", 200);
    idle(12);
    chk("pass5_queue_left", sb_q.size(), 32'd0);
    chk("pass5_done_count", done_count - dc0, 32'd1);

    // Zero entries: only LOAD and FIN are busy.
    done_after_hs = 1'b0;
    busy_cycles   = 0;
    dc0           = done_count;
    do_start(0);
    wait_done("pass0", 20);
    idle(4);
    chk("pass0_busy_cycles", busy_cycles, 32'd2);
    chk("pass0_done_count", done_count - dc0, 32'd1);

    // Oversized request clamps to DEPTH with no address past DEPTH-1.
    for (int i = DEPTH; i < 512; i++) mem[i] = '1;
    for (int i = 0; i < DEPTH; i++) sb_q.push_back(DATA_W'(i * 3));
    done_after_hs = 1'b1;
    max_addr      = 0;
    dc0           = done_count;
    do_start(511);
    wait_done("pass511", 2500);
    chk("pass511_max_addr", max_addr, DEPTH - 1);
    chk("pass511_queue_left", sb_q.size(), 32'd0);
    chk("pass511_done_count", done_count - dc0, 32'd1);

    // Random back-pressure.
    tp_check   = 1'b0;
    ready_rand = 1'b1;
    for (int i = 0; i < 20; i++) sb_q.push_back(DATA_W'(i * 3));
    do_start(20);
    wait_done("pass_rand", 3000);
    chk("pass_rand_queue_left", sb_q.size(), 32'd0);
    ready_rand = 1'b0;

    // Reset while entry 7 is being presented, then replay from entry 0.
    for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'(i * 5 + 2);
    for (int i = 0; i < 20; i++) sb_q.push_back(DATA_W'(i * 5 + 2));
    tp_check    = 1'b1;
    ready_level = 1'b1;
    hs0         = hs_count;
    do_start(20);
    got = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clock);
      #1;
      if (hs_count - hs0 == 7) begin
        got = 1'b1;
        break;
      end
    end
    ready_level = 1'b0;
    if (got) begin
      got = 1'b0;
      for (int k = 0; k < 50; k++) begin
        @(negedge clock);
        #1;
        if (pix_valid) begin
          got = 1'b1;
          break;
        end
      end
    end
    chk("rst7_reached_present", 32'(got), 32'd1);
    chk("rst7_stalled_addr", 32'(pix_addr), 32'd37);
    #2 reset = 1'b1;
    #1;
    chk("rst7_pix_valid", 32'(pix_valid), 32'd0);
    chk("rst7_busy", 32'(busy), 32'd0);
    sb_q.delete();
    idle(2);
    #2 reset = 1'b0;
    ready_level = 1'b1;
    for (int i = 0; i < 5; i++) sb_q.push_back(DATA_W'(i * 5 + 2));
    do_start(5);
    wait_done("replay", 200);
    chk("replay_queue_left", sb_q.size(), 32'd0);

`ifdef TRAJ_BOUNDS_CHECK_EN
    // Off-screen entries are dropped and counted.
    mem[0] = 19'd10;
    mem[1] = 19'd307200;
    mem[2] = 19'd500000;
    mem[3] = 19'd20;
    sb_q.push_back(19'd10);
    sb_q.push_back(19'd20);
    tp_check = 1'b0;
    dc0      = done_count;
    do_start(4);
    wait_done("bounds", 200);
    chk("bounds_drop_count", 32'(drop_count), 32'd2);
    chk("bounds_queue_left", sb_q.size(), 32'd0);
    chk("bounds_done_count", done_count - dc0, 32'd1);
`endif

    idle(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion required finish before 1 ms");
    $fatal(1, "watchdog expired");
  end

endmodule
